// File: rtl/cpu_defs.sv
// Shared CPU definitions: default datapath widths and control-bundle bit map.
package cpu_defs;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 16;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_ALUOP_LO = 5;
  localparam int CTRL_ALUOP_HI = 7;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded ID fields and WB write port in,
// registered EX fields and hazard status out.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
);
  logic              stall_i;
  logic              flush_i;
  logic              valid_i;
  logic              uses_rt_i;
  logic [ADDR_W-1:0] RSaddr_i;
  logic [ADDR_W-1:0] RTaddr_i;
  logic [ADDR_W-1:0] RDaddr_i;
  logic [DATA_W-1:0] RSdata_i;
  logic [DATA_W-1:0] RTdata_i;
  logic [DATA_W-1:0] imm_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic              wb_we_i;
  logic [ADDR_W-1:0] wb_addr_i;
  logic [DATA_W-1:0] wb_data_i;

  logic              valid_o;
  logic [ADDR_W-1:0] RSaddr_o;
  logic [ADDR_W-1:0] RTaddr_o;
  logic [ADDR_W-1:0] RDaddr_o;
  logic [DATA_W-1:0] RSdata_o;
  logic [DATA_W-1:0] RTdata_o;
  logic [DATA_W-1:0] imm_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic              hazard_stall_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  modport slave (
    input  stall_i, flush_i, valid_i, uses_rt_i,
    input  RSaddr_i, RTaddr_i, RDaddr_i,
    input  RSdata_i, RTdata_i, imm_i, ctrl_i,
    input  wb_we_i, wb_addr_i, wb_data_i,
    output valid_o, RSaddr_o, RTaddr_o, RDaddr_o,
    output RSdata_o, RTdata_o, imm_o, ctrl_o,
    output hazard_stall_o, bubble_cnt_o
  );

  modport master (
    output stall_i, flush_i, valid_i, uses_rt_i,
    output RSaddr_i, RTaddr_i, RDaddr_i,
    output RSdata_i, RTdata_i, imm_i, ctrl_i,
    output wb_we_i, wb_addr_i, wb_data_i,
    input  valid_o, RSaddr_o, RTaddr_o, RDaddr_o,
    input  RSdata_o, RTdata_o, imm_o, ctrl_o,
    input  hazard_stall_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_bypass_mux.sv
// Operand select: $0 reads zero, a same-cycle WB write to the
// addressed register wins over the (stale) register file read.
module id_bypass_mux #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] op_o
);

  always_comb begin
    op_o = rf_data_i;
    if (addr_i == '0) begin
      op_o = '0;
    end else if (wb_we_i && wb_addr_i == addr_i) begin
      op_o = wb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB->ID bypass, load-use bubble
// insertion and a saturating bubble counter.
module id_ex_stage
  import cpu_defs::*;
#(
  parameter int DATA_W = cpu_defs::DATA_W,
  parameter int ADDR_W = cpu_defs::ADDR_W,
  parameter int CTRL_W = cpu_defs::CTRL_W,
  parameter int CNT_W  = cpu_defs::CNT_W
) (
  input logic          clk_i,
  input logic          rst_i,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rs_a;
    logic [ADDR_W-1:0] rt_a;
    logic [ADDR_W-1:0] rd_a;
    logic [DATA_W-1:0] rs_d;
    logic [DATA_W-1:0] rt_d;
    logic [DATA_W-1:0] imm;
    logic [CTRL_W-1:0] ctrl;
  } ex_t;

  ex_t              ex_q, ex_d, load;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rs_op, rt_op;
  logic             hazard;
  logic             src_hit;

  id_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs_mux (
    .addr_i    (bus.RSaddr_i),
    .rf_data_i (bus.RSdata_i),
    .wb_we_i   (bus.wb_we_i),
    .wb_addr_i (bus.wb_addr_i),
    .wb_data_i (bus.wb_data_i),
    .op_o      (rs_op)
  );

  id_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rt_mux (
    .addr_i    (bus.RTaddr_i),
    .rf_data_i (bus.RTdata_i),
    .wb_we_i   (bus.wb_we_i),
    .wb_addr_i (bus.wb_addr_i),
    .wb_data_i (bus.wb_data_i),
    .op_o      (rt_op)
  );

  // Load in EX whose result is still in flight to a source of ID
  assign src_hit = (ex_q.rd_a == bus.RSaddr_i)
                || (bus.uses_rt_i && ex_q.rd_a == bus.RTaddr_i);
  assign hazard  = ex_q.valid && ex_q.ctrl[CTRL_MEMREAD]
                && (ex_q.rd_a != '0) && bus.valid_i && src_hit;

  always_comb begin
    load       = '0;
    load.valid = bus.valid_i;
    load.rs_a  = bus.RSaddr_i;
    load.rt_a  = bus.RTaddr_i;
    load.rd_a  = bus.RDaddr_i;
    load.rs_d  = rs_op;
    load.rt_d  = rt_op;
    load.imm   = bus.imm_i;
    load.ctrl  = bus.valid_i ? bus.ctrl_i : '0;
  end

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (bus.flush_i) begin
      ex_d = '0;
    end else if (!bus.stall_i) begin
      if (hazard) begin
        ex_d  = '0;
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
        ex_d = load;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.valid_o        = ex_q.valid;
  assign bus.RSaddr_o       = ex_q.rs_a;
  assign bus.RTaddr_o       = ex_q.rt_a;
  assign bus.RDaddr_o       = ex_q.rd_a;
  assign bus.RSdata_o       = ex_q.rs_d;
  assign bus.RTdata_o       = ex_q.rt_d;
  assign bus.imm_o          = ex_q.imm;
  assign bus.ctrl_o         = ex_q.ctrl;
  assign bus.hazard_stall_o = hazard && !bus.flush_i;
  assign bus.bubble_cnt_o   = cnt_q;

endmodule
